// File: rtl/rr_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
//   NUM_CH  : number of requesting channels
//   DATA_W  : channel / bus data width
//   SEL_W   : width of a channel index
//   CNT_W   : width of the per-grant beat counter
package rr_bus_arbiter_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One-hot encode a channel index.
  function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_CH'(1) << idx;
  endfunction

endpackage : rr_bus_arbiter_pkg

// File: rtl/rr_bus_arbiter_if.sv
// Request/data/grant bundle between requesters, arbiter and downstream bus.
//   req, d0..d7, bus_ready  : requester / downstream side inputs to the arbiter
//   gnt, sel, bus_valid,
//   databus, beat_cnt       : arbiter outputs
// Modports: slave = arbiter view, master = environment view.
interface rr_bus_arbiter_if;
  import rr_bus_arbiter_pkg::*;

  logic [NUM_CH-1:0] req;
  logic [DATA_W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic              bus_ready;
  logic [NUM_CH-1:0] gnt;
  logic [SEL_W-1:0]  sel;
  logic              bus_valid;
  logic [DATA_W-1:0] databus;
  logic [CNT_W-1:0]  beat_cnt;

  modport slave (
    input  req, d0, d1, d2, d3, d4, d5, d6, d7, bus_ready,
    output gnt, sel, bus_valid, databus, beat_cnt
  );

  modport master (
    output req, d0, d1, d2, d3, d4, d5, d6, d7, bus_ready,
    input  gnt, sel, bus_valid, databus, beat_cnt
  );

endinterface : rr_bus_arbiter_if

// File: rtl/rr_bus_arbiter_pick8.sv
// Combinational round-robin search over 8 requests.
//   req   : request vector
//   ptr   : last granted index; search starts at ptr+1 and wraps to ptr
//   found : any request set
//   idx   : first set request in search order (0 when none)
module rr_pick8
  import rr_bus_arbiter_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Offsets 1..8 wrap modulo 8, so ptr itself is tried last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick8

// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting one of 8 channels the shared data bus for up
// to MAX_BURST accepted beats per grant, with back-to-back regrant.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave modport (req, d0..d7, bus_ready in;
//                gnt, sel, bus_valid, databus, beat_cnt out)
module rr_bus_arbiter
  import rr_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_bus_arbiter_if.slave  bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("rr_bus_arbiter: MAX_BURST must be in 1..15");
  end

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              idle_found, rel_found;
  logic [SEL_W-1:0]  idle_idx, rel_idx;
  logic              accept, last_beat, rel;
  logic [DATA_W-1:0] mux_data;

  // Fresh arbitration from the stored pointer while idle.
  rr_pick8 u_pick_idle (
    .req   (bus.req),
    .ptr   (ptr_q),
    .found (idle_found),
    .idx   (idle_idx)
  );

  // Regrant search on release uses the pointer as it will be loaded (sel),
  // which makes the releasing channel the lowest priority.
  rr_pick8 u_pick_rel (
    .req   (bus.req),
    .ptr   (sel_q),
    .found (rel_found),
    .idx   (rel_idx)
  );

  assign accept    = valid_q & bus.bus_ready;
  assign last_beat = accept && (cnt_q == CNT_W'(MAX_BURST - 1));
  assign rel       = !bus.req[sel_q] || last_beat;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SEL_W'(NUM_CH - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (idle_found) begin
          state_d = BUSY;
          sel_d   = idle_idx;
          gnt_d   = onehot(idle_idx);
          valid_d = 1'b1;
          cnt_d   = '0;
        end
      end

      BUSY: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (rel) begin
          ptr_d = sel_q;
          if (rel_found) begin
            sel_d = rel_idx;
            gnt_d = onehot(rel_idx);
            cnt_d = '0;
          end else begin
            state_d = IDLE;
            sel_d   = '0;
            gnt_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = '0;
        gnt_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // 8-to-1 data select driven by the registered channel index.
  always_comb begin
    mux_data = '0;
    case (sel_q)
      3'd0:    mux_data = bus.d0;
      3'd1:    mux_data = bus.d1;
      3'd2:    mux_data = bus.d2;
      3'd3:    mux_data = bus.d3;
      3'd4:    mux_data = bus.d4;
      3'd5:    mux_data = bus.d5;
      3'd6:    mux_data = bus.d6;
      3'd7:    mux_data = bus.d7;
      default: mux_data = '0;
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.bus_valid = valid_q;
  assign bus.beat_cnt  = cnt_q;
  assign bus.databus   = valid_q ? mux_data : '0;

endmodule : rr_bus_arbiter

// File: tb/tb_rr_bus_arbiter.sv
// Directed scoreboard bench for rr_bus_arbiter (MAX_BURST = 4).
module tb_rr_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_bus_arbiter_if bus ();

  rr_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        valid;
    logic [3:0]  cnt;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] dval[8];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected bus state for a channel index (or idle).
  task automatic push_exp(input int s, input logic v, input int c);
    exp_t e;
    logic [2:0] si;
    si      = v ? 3'(s) : 3'd0;
    e.sel   = si;
    e.gnt   = v ? (8'd1 << si) : 8'd0;
    e.valid = v;
    e.cnt   = 4'(c);
    e.data  = v ? dval[si] : 32'h0;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ".gnt"},      32'(bus.gnt),       32'(e.gnt));
      chk({tag, ".sel"},      32'(bus.sel),       32'(e.sel));
      chk({tag, ".valid"},    32'(bus.bus_valid), 32'(e.valid));
      chk({tag, ".beat_cnt"}, 32'(bus.beat_cnt),  32'(e.cnt));
      chk({tag, ".databus"},  bus.databus,        e.data);
    end
  endtask

  // Expectation for the state after the next rising edge.
  task automatic edge_exp(input string tag, input int s, input logic v, input int c);
    push_exp(s, v, c);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  // Expectation for the state right now (no clock edge).
  task automatic now_exp(input string tag, input int s, input logic v, input int c);
    push_exp(s, v, c);
    pop_cmp(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 8'h00;
    bus.bus_ready = 1'b0;
    #1;
    now_exp("reset", 0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int grants_a[3];
    grants_a = '{0, 2, 0};
    for (int i = 0; i < 8; i++) dval[i] = 32'hC0DE_0000 + 32'(i * 32'h1111);
    bus.d0 = dval[0]; bus.d1 = dval[1]; bus.d2 = dval[2]; bus.d3 = dval[3];
    bus.d4 = dval[4]; bus.d5 = dval[5]; bus.d6 = dval[6]; bus.d7 = dval[7];

    // Two requesters, bursts alternate with no idle cycle.
    do_reset();
    bus.req = 8'h05;
    bus.bus_ready = 1'b1;
    for (int g = 0; g < 3; g++)
      for (int k = 0; k < 4; k++)
        edge_exp($sformatf("two_req_g%0d_b%0d", g, k), grants_a[g], 1'b1, k);
    bus.req = 8'h00;
    edge_exp("two_req_release_idle", 0, 1'b0, 0);
    edge_exp("idle_ready_ignored", 0, 1'b0, 0);

    // All channels requesting: full rotation 0..7,0 of 4-beat bursts.
    do_reset();
    bus.req = 8'hFF;
    bus.bus_ready = 1'b1;
    for (int g = 0; g < 9; g++)
      for (int k = 0; k < 4; k++)
        edge_exp($sformatf("all_req_ch%0d_b%0d", g % 8, k), g % 8, 1'b1, k);
    bus.req = 8'h00;
    edge_exp("all_req_release_idle", 0, 1'b0, 0);

    // Stall on ch3; unrelated requests must not disturb the grant.
    bus.req = 8'h08;
    bus.bus_ready = 1'b0;
    edge_exp("stall_grant", 3, 1'b1, 0);
    bus.req = 8'hFF;
    for (int k = 0; k < 5; k++) edge_exp($sformatf("stall_hold%0d", k), 3, 1'b1, 0);
    bus.req = 8'h08;
    bus.bus_ready = 1'b1;
    for (int k = 1; k < 4; k++) edge_exp($sformatf("stall_beat%0d", k), 3, 1'b1, k);
    edge_exp("stall_sole_regrant", 3, 1'b1, 0);
    bus.req = 8'h00;
    bus.bus_ready = 1'b0;
    edge_exp("stall_drop_idle", 0, 1'b0, 0);

    // ch5 drops its request after two accepted beats.
    bus.req = 8'h20;
    bus.bus_ready = 1'b1;
    for (int k = 0; k < 3; k++) edge_exp($sformatf("early_b%0d", k), 5, 1'b1, k);
    bus.req = 8'h00;
    edge_exp("early_release_idle", 0, 1'b0, 0);
    // Pointer now 5: ch0 beats ch4 (ch4 would win from pointer 3).
    bus.req = 8'h11;
    edge_exp("ptr_after_early", 0, 1'b1, 0);

    // Sole requester ch6 regranted back-to-back, valid never drops.
    bus.req = 8'h40;
    edge_exp("solo_first", 6, 1'b1, 0);
    for (int g = 0; g < 3; g++)
      for (int k = 1; k <= 4; k++)
        edge_exp($sformatf("solo_g%0d_b%0d", g, k), 6, 1'b1, k % 4);

    // Asynchronous reset mid-burst on ch2.
    bus.req = 8'h04;
    edge_exp("async_grant", 2, 1'b1, 0);
    edge_exp("async_beat1", 2, 1'b1, 1);
    #3;
    rst_n = 1'b0;
    #1;
    now_exp("async_reset_now", 0, 1'b0, 0);
    #2;
    rst_n = 1'b1;
    edge_exp("after_reset_grant", 2, 1'b1, 0);
    edge_exp("after_reset_beat1", 2, 1'b1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rr_bus_arbiter

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 Parameter MAX_BURST, 4, maximum beats per grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  8  request per channel; bit i corresponds to data input di.
REQ-005 d0..d7  input  32 each  channel data words.
REQ-006 bus_ready  input  1  downstream accepts the current beat.
REQ-007 gnt  output  8  one-hot grant, registered; all zeros when no grant.
REQ-008 sel  output  3  index of the granted channel, registered.
REQ-009 bus_valid  output  1  databus carries a valid beat, registered.
REQ-010 databus  output  32  d[sel] while bus_valid=1, else 32'h0000_0000.
REQ-011 beat_cnt  output  4  beats accepted in the current grant.

Function
REQ-012 The FSM SHALL have two states: IDLE (no grant) and BUSY (one channel granted).
REQ-013 The round-robin pointer ptr (3 bits) SHALL hold the last granted index; search order is ptr+1, ptr+2, ... ptr, modulo 8.
REQ-014 In IDLE with req!=0 at edge N, the FSM SHALL enter BUSY at edge N+1 with sel = first set req bit in search order, gnt = one-hot(sel), bus_valid=1, beat_cnt=0.
REQ-015 In IDLE with req==0, outputs SHALL hold reset values.
REQ-016 A beat SHALL be accepted on an edge where bus_valid=1 and bus_ready=1; beat_cnt increments by 1 on each accepted beat.
REQ-017 databus SHALL be combinational from registered sel and d0..d7; the granted requester holds its data stable until its beat is accepted.
REQ-018 Release SHALL occur at an edge in BUSY where (a) req[sel]=0, or (b) a beat is accepted and beat_cnt+1 == MAX_BURST.
REQ-019 On release, ptr SHALL load sel; with another search over req (new ptr) in the same edge: any set bit -> stay BUSY, regrant back-to-back with beat_cnt=0; none -> IDLE, gnt=0, bus_valid=0.
REQ-020 Back-to-back regrant SHALL include the released channel only if it is the sole requester (lowest priority after ptr update).
REQ-021 req[sel] falling with bus_ready=1 on the same edge SHALL count the beat (beat_cnt updates) and release.
REQ-022 Changes on req bits other than sel SHALL NOT affect an active grant.
REQ-023 bus_ready SHALL be ignored while bus_valid=0.
REQ-024 gnt SHALL never have more than one bit set; sel SHALL equal the index of the set gnt bit whenever gnt!=0.
REQ-025 beat_cnt SHALL never exceed MAX_BURST-1 while BUSY.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, gnt=0, sel=0, bus_valid=0, databus=0, beat_cnt=0, ptr=7 (channel 0 highest priority first).
REQ-027 Reset asserted mid-burst SHALL abandon the beat without completion; after rst_n rises, first arbitration follows REQ-014.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, BUSY), NUM_CH=8, DATA_W=32, SEL_W=3, CNT_W=4.
REQ-029 The combinational round-robin search SHALL be a sub-module rr_pick8 (inputs req, ptr; outputs found, idx), instantiated twice or shared.
REQ-030 The data selection SHALL be an 8-to-1 32-bit case-based mux inside rr_bus_arbiter.

Verification
REQ-031 After reset, req=8'b0000_0101, bus_ready=1 held -> next edge gnt=8'h01, sel=0, databus=d0; after 4 beats gnt=8'h04, sel=2, databus=d2, no idle cycle between.
REQ-032 req=8'hFF continuous, bus_ready=1, MAX_BURST=4 -> grants 0,1,...,7,0 each lasting exactly 4 beats; beat_cnt cycles 0..3.
REQ-033 Grant on ch3, bus_ready=0 for 5 cycles -> databus=d3 stable, beat_cnt=0, gnt=8'h08 unchanged throughout.
REQ-034 Grant on ch5, req[5] falls after 2 accepted beats, req=0 otherwise -> next edge IDLE, gnt=0, bus_valid=0, databus=0, ptr=5.
REQ-035 Only req[6]=1, held -> ch6 regranted back-to-back after every 4 beats, bus_valid never drops.
REQ-036 rst_n driven low between edges mid-burst on ch2 -> gnt, bus_valid, databus go to 0 without waiting for clk; after release with req=8'h04 -> ch2 granted at first edge.
